// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: request/response handshake to a variable-latency data memory,
// with byte-lane steering, load extension, pipeline stall and a watchdog abort.
module lsu_mem_stage #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  localparam int WD_W = $clog2(MAX_WAIT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  state_t          state_q, state_d;
  logic [WD_W-1:0] wd_cnt;
  logic [2:0]      funct3_q;
  logic [1:0]      offset_q;
  logic            legal, wd_expire;
  logic            issue, reject, finish, capture, abort;

  function automatic logic req_legal(input logic we, input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = ~off[0];
      3'b010:  ok = (off == 2'b00);
      3'b100:  ok = ~we;
      3'b101:  ok = ~we & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << {off[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate narrow store data so the enabled lanes carry it whatever the offset.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] w);
    logic [31:0] d;
    case (size)
      2'b00:   d = {4{w[7:0]}};
      2'b01:   d = {2{w[15:0]}};
      default: d = w;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    issue     = 1'b0;
    reject    = 1'b0;
    finish    = 1'b0;
    capture   = 1'b0;
    abort     = 1'b0;
    legal     = req_legal(req_we, req_funct3, req_addr[1:0]);
    wd_expire = (wd_cnt >= WD_LAST);
    case (state_q)
      IDLE: begin
        busy = req_valid;
        if (req_valid) begin
          if (legal) begin
            issue   = 1'b1;
            state_d = REQ;
          end else begin
            reject  = 1'b1;
            state_d = DONE;
          end
        end
      end
      REQ: begin
        busy = 1'b1;
        if (mem_ready) begin
          if (mem_we) begin
            finish  = 1'b1;
            state_d = DONE;
          end else if (mem_rvalid) begin
            capture = 1'b1;
            state_d = DONE;
          end else begin
            state_d = WAIT_R;
          end
        end else if (wd_expire) begin
          abort   = 1'b1;
          state_d = DONE;
        end
      end
      WAIT_R: begin
        busy = 1'b1;
        if (mem_rvalid) begin
          capture = 1'b1;
          state_d = DONE;
        end else if (wd_expire) begin
          abort   = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request issue, handshake and completion registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wd_cnt    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      rsp_valid <= 1'b0;
      err       <= 1'b0;
      if ((state_q == REQ || state_q == WAIT_R) && (state_d == REQ || state_d == WAIT_R))
        wd_cnt <= wd_cnt + 1'b1;
      else
        wd_cnt <= '0;
      if (issue) begin
        mem_req   <= 1'b1;
        mem_we    <= req_we;
        mem_addr  <= {req_addr[31:2], 2'b00};
        mem_be    <= byte_en(req_funct3[1:0], req_addr[1:0]);
        mem_wdata <= store_data(req_funct3[1:0], req_wdata);
      end
      if (state_q == REQ && (mem_ready || abort))
        mem_req <= 1'b0;
      if (reject || abort || finish || capture) begin
        rsp_valid <= 1'b1;
        err       <= reject | abort;
        rsp_rdata <= capture ? load_extract(funct3_q, offset_q, mem_rdata) : '0;
      end
    end
  end

  // Access attributes needed only at load capture
  always_ff @(posedge clk) begin
    if (issue) begin
      funct3_q <= req_funct3;
      offset_q <= req_addr[1:0];
    end
  end
endmodule
